// File: rtl/accumulator_top.sv
// Sums a fixed block of 1024 unsigned 32-bit samples in four interleaved lanes,
// then reduces the lanes in two steps into a registered result that holds until reset.
module accumulator_top (
    input  logic        clk,
    input  logic        clk_core,
    input  logic        reset,
    input  logic [31:0] load,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        REDUCE1 = 2'd1,
        REDUCE2 = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [10:0] LAST_SAMPLE = 11'd1023;

    state_e      state_q, state_d;
    logic [10:0] cnt_q,   cnt_d;
    logic [31:0] lane_q [4];
    logic [31:0] lane_d [4];
    logic [31:0] p0_q, p0_d;
    logic [31:0] p1_q, p1_d;
    logic [31:0] result_q, result_d;

    // Kept only for port-order compatibility; the pin is tied to clk and clocks nothing.
    logic unused_clk_core;
    assign unused_clk_core = clk_core;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            p0_q     <= '0;
            p1_q     <= '0;
            result_q <= '0;
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            result_q <= result_d;
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    // NOTE: every next-state value defaults to its current value first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        result_d = result_q;
        for (int i = 0; i < 4; i++) begin
            lane_d[i] = lane_q[i];
        end

        case (state_q)
            RUN: begin
                lane_d[cnt_q[1:0]] = lane_q[cnt_q[1:0]] + load;
                cnt_d              = cnt_q + 11'd1;
                if (cnt_q == LAST_SAMPLE) begin
                    state_d = REDUCE1;
                end
            end
            REDUCE1: begin
                p0_d    = lane_q[0] + lane_q[1];
                p1_d    = lane_q[2] + lane_q[3];
                state_d = REDUCE2;
            end
            REDUCE2: begin
                result_d = p0_q + p1_q;
                state_d  = DONE;
            end
            DONE: begin
                // Result frozen; load is ignored until the next reset.
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign result = result_q;

endmodule

// File: tb/tb_accumulator_top.sv
// Directed self-checking bench for accumulator_top: full blocks with known sums,
// wrap-around, hold in DONE, and reset mid-block / in DONE.
module tb_accumulator_top;

    logic        clk;
    logic        reset;
    logic [31:0] load;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    accumulator_top dut (
        .clk      (clk),
        .clk_core (clk),
        .reset    (reset),
        .load     (load),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entered at a negedge after at least one edge with reset high. Drives 1024
    // samples, then after_val, and checks result is 0 through RUN/REDUCE1/REDUCE2
    // and equals expected two edges after the last sample.
    task automatic run_block(input logic [31:0] samples [1024], input logic [31:0] after_val,
                             input logic [31:0] expected, input string name);
        int zero_bad = 0;
        reset = 1'b0;
        for (int k = 0; k < 1024; k++) begin
            load = samples[k];
            @(negedge clk);
            if (result !== 32'd0) zero_bad++;
        end
        load = after_val;
        total++;
        if (zero_bad != 0) begin
            bad++;
            $display("FAIL %s_zero_during_run: nonzero result seen %0d times, required 0 times", name, zero_bad);
        end
        @(negedge clk);
        total++;
        if (result !== 32'd0) begin
            bad++;
            $display("FAIL %s_zero_in_reduce2: result=0x%08h required=0x00000000", name, result);
        end
        @(negedge clk);
        total++;
        if (result !== expected) begin
            bad++;
            $display("FAIL %s_final: result=0x%08h required=0x%08h", name, result, expected);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        load  = 32'hA5A5_A5A5;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load  = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        total++;
        if (result !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: result=0x%08h required=0x00000000", result);
        end
    endtask

    task automatic test_ones();
        logic [31:0] s [1024];
        for (int k = 0; k < 1024; k++) s[k] = 32'd1;
        run_block(s, 32'h1234_5678, 32'h0000_0400, "ones");
    endtask

    task automatic test_ramp();
        logic [31:0] s [1024];
        apply_reset();
        total++;
        if (result !== 32'd0) begin
            bad++;
            $display("FAIL reset_in_done: result=0x%08h required=0x00000000", result);
        end
        for (int k = 0; k < 1024; k++) s[k] = k;
        run_block(s, 32'hDEAD_BEEF, 32'h0007_FE00, "ramp");
    endtask

    task automatic test_wrap();
        logic [31:0] s [1024];
        apply_reset();
        for (int k = 0; k < 1024; k++) s[k] = 32'h0000_FFFF;
        run_block(s, 32'hFFFF_FFFF, 32'h03FF_FC00, "ffff");
        apply_reset();
        for (int k = 0; k < 1024; k++) s[k] = 32'hFFFF_FFFF;
        run_block(s, 32'h0000_0001, 32'hFFFF_FC00, "wrap");
    endtask

    task automatic test_random_hold();
        logic [31:0] s [1024];
        logic [31:0] ref_sum = 32'd0;
        int changed = 0;
        apply_reset();
        for (int k = 0; k < 1024; k++) begin
            s[k]    = {16'd0, 16'($urandom_range(0, 65535))};
            ref_sum = ref_sum + s[k];
        end
        run_block(s, 32'd0, ref_sum, "random");
        for (int c = 0; c < 100; c++) begin
            load = $urandom;
            @(negedge clk);
            if (result !== ref_sum) changed++;
        end
        total++;
        if (changed != 0) begin
            bad++;
            $display("FAIL random_hold_in_done: result changed %0d times, now=0x%08h required=0x%08h",
                     changed, result, ref_sum);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] s [1024];
        apply_reset();
        reset = 1'b0;
        for (int k = 0; k <= 500; k++) begin
            load = 32'd7 + k;
            @(negedge clk);
        end
        reset = 1'b1;
        load  = 32'd99;
        @(negedge clk);
        total++;
        if (result !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset_clear: result=0x%08h required=0x00000000", result);
        end
        for (int k = 0; k < 1024; k++) s[k] = 32'd2;
        run_block(s, 32'h0BAD_F00D, 32'h0000_0800, "mid_reset");
    endtask

    initial begin
        reset = 1'b1;
        load  = 32'd0;
        test_reset();
        test_ones();
        test_ramp();
        test_wrap();
        test_random_hold();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accumulator_top.md
ACCUMULATOR_TOP -- requirements
Module: accumulator_top

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 clk_core  input  1  second clock pin, kept for port-order compatibility; SHALL be tied to the clk net and SHALL clock no logic.
REQ-004 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 load  input  32  sample value; one sample captured per clock while running.
REQ-006 result  output  32  registered final sum of one 1024-sample block; 0 until complete.
REQ-007 Port order SHALL be clk, clk_core, reset, load, result.

Function
REQ-008 Block length SHALL be fixed at 1024 samples; sample counter 11 bits (0..1024).
REQ-009 Sample k (k = 0..1023) SHALL be the value of load at the k-th rising edge after the first edge with reset low, k = 0 being that first edge itself.
REQ-010 Four parallel 32-bit lane accumulators SHALL be used; sample k SHALL be added into lane (k mod 4).
REQ-011 All additions SHALL be unsigned, modulo 2^32; no saturation, no overflow flag.
REQ-012 States: RUN (capturing), REDUCE1, REDUCE2, DONE.
REQ-013 RUN -> REDUCE1 on the edge capturing sample 1023.
REQ-014 REDUCE1: one edge; SHALL form partials p0 = lane0 + lane1 and p1 = lane2 + lane3.
REQ-015 REDUCE2: one edge; SHALL load result with p0 + p1, then enter DONE.
REQ-016 Latency: result SHALL hold the total 2 clocks after the edge capturing sample 1023.
REQ-017 DONE SHALL hold result constant and ignore load until reset.
REQ-018 Samples arriving after sample 1023 SHALL never affect lanes or result.
REQ-019 result SHALL read 0 throughout RUN, REDUCE1 and REDUCE2.
REQ-020 No combinational path from load or reset to result.

Reset
REQ-021 While reset is high at a rising edge, the following SHALL be cleared:
- lanes, partials, sample counter and result cleared to 0
- state set to RUN
REQ-022 Reset asserted mid-block or in DONE SHALL discard all accumulated data.
- Counting restarts at sample 0 on the first edge with reset low.
REQ-023 Reset has priority over capture and reduction on the same edge.

Verification
REQ-024 reset 2 cycles, then load=1 for 1024 cycles -> result 0 until 2 cycles after last sample, then 0x00000400.
REQ-025 load = k for sample k (0..1023) -> result = 523776 (0x0007FE00).
REQ-026 load=0x0000FFFF for 1024 samples -> result = 0x03FFFC00; load=0xFFFFFFFF for 1024 samples -> result = 0xFFFFFC00 (wrap).
REQ-027 1024 random 16-bit samples, load=0 afterwards -> result equals the reference sum mod 2^32 and stays constant for 100 further cycles of random load.
REQ-028 Reset pulsed after sample 500, then 1024 samples of value 2 -> result 0 until completion, then 0x00000800 (pre-reset data excluded).
